// File: rtl/work_loader.sv
`default_nettype none
// ============================================================================
//  Module   : work_loader
//  Purpose  : Byte-serial work receiver for the mining core. Deserialises a
//             framed stream (sync A5 + 44 payload bytes [+ XOR checksum]) into
//             a 256-bit midstate and a 96-bit header tail, then commits both
//             registers and pulses work_valid. Aborts on inter-byte timeout.
//  Options  : WORK_LOADER_CHECKSUM_EN - when defined, a trailing XOR checksum
//             byte is required and checked before commit.
//  Revision : 1.0 - initial release
// ============================================================================
module work_loader #(
    parameter logic [31:0] TIMEOUT = 32'd1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [255:0] midstate,
    output logic [95:0]  data,
    output logic         work_valid,
    output logic         frame_err
);

    localparam logic [7:0] C_SYNC_BYTE = 8'hA5;
    localparam logic [5:0] C_LAST_BYTE = 6'd43;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
`ifdef WORK_LOADER_CHECKSUM_EN
        S_CHECK   = 2'd3,
`endif
        S_COMMIT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [351:0]   shadow_q, shadow_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [31:0]    idle_q, idle_d;
    logic           in_ready_q, in_ready_d;
    logic [255:0]   midstate_q, midstate_d;
    logic [95:0]    data_q, data_d;
    logic           work_valid_q, work_valid_d;
    logic           frame_err_q, frame_err_d;
`ifdef WORK_LOADER_CHECKSUM_EN
    logic [7:0]     xor_q, xor_d;
`endif

    logic w_xfer;
    logic w_timeout;

    assign w_xfer    = in_valid && in_ready_q;
    // Fires on the edge where the idle run would reach TIMEOUT.
    assign w_timeout = !w_xfer && (idle_q == (TIMEOUT - 32'd1));

    // Next-state, shadow assembly, timeout and commit logic.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        cnt_d        = cnt_q;
        idle_d       = 32'd0;
        midstate_d   = midstate_q;
        data_d       = data_q;
        work_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef WORK_LOADER_CHECKSUM_EN
        xor_d        = xor_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Anything other than the sync byte is consumed and dropped.
                if (w_xfer && (in_data == C_SYNC_BYTE)) begin
                    state_d = S_PAYLOAD;
                    cnt_d   = 6'd0;
`ifdef WORK_LOADER_CHECKSUM_EN
                    xor_d   = 8'd0;
`endif
                end
            end
            S_PAYLOAD: begin
                // A5 here is ordinary payload; there is no mid-frame resync.
                if (w_xfer) begin
                    shadow_d = {shadow_q[343:0], in_data};
                    cnt_d    = cnt_q + 6'd1;
`ifdef WORK_LOADER_CHECKSUM_EN
                    xor_d    = xor_q ^ in_data;
                    if (cnt_q == C_LAST_BYTE) state_d = S_CHECK;
`else
                    if (cnt_q == C_LAST_BYTE) state_d = S_COMMIT;
`endif
                end else if (w_timeout) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    idle_d = idle_q + 32'd1;
                end
            end
`ifdef WORK_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_xfer) begin
                    if (in_data == xor_q) begin
                        state_d = S_COMMIT;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end else if (w_timeout) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    idle_d = idle_q + 32'd1;
                end
            end
`endif
            S_COMMIT: begin
                midstate_d   = shadow_q[351:96];
                data_d       = shadow_q[95:0];
                work_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Registered ready: low exactly while COMMIT is held.
        in_ready_d = (state_d != S_COMMIT);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            shadow_q     <= '0;
            cnt_q        <= 6'd0;
            idle_q       <= 32'd0;
            in_ready_q   <= 1'b0;
            midstate_q   <= '0;
            data_q       <= '0;
            work_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef WORK_LOADER_CHECKSUM_EN
            xor_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            cnt_q        <= cnt_d;
            idle_q       <= idle_d;
            in_ready_q   <= in_ready_d;
            midstate_q   <= midstate_d;
            data_q       <= data_d;
            work_valid_q <= work_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef WORK_LOADER_CHECKSUM_EN
            xor_q        <= xor_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign midstate   = midstate_q;
    assign data       = data_q;
    assign work_valid = work_valid_q;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_work_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_work_loader
//  Purpose  : Randomised scoreboard bench for work_loader. Frames are built
//             from byte arrays; the expected commit/error events (with their
//             cycle) are queued by the driver and popped by a monitor.
//             Honors WORK_LOADER_CHECKSUM_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_work_loader;

    localparam int C_TO = 16;
`ifdef WORK_LOADER_CHECKSUM_EN
    localparam int C_PERIOD = 47;
`else
    localparam int C_PERIOD = 46;
`endif

    logic         clk;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] midstate;
    logic [95:0]  data;
    logic         work_valid;
    logic         frame_err;

    work_loader #(.TIMEOUT(32'(C_TO))) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .midstate   (midstate),
        .data       (data),
        .work_valid (work_valid),
        .frame_err  (frame_err)
    );

    typedef struct {
        bit           is_commit;
        logic [255:0] mid;
        logic [95:0]  dat;
        int           cyc;
    } ev_t;

    ev_t          sb[$];
    int           vectors    = 0;
    int           miscompares = 0;
    int           cyc        = 0;
    bit           live       = 0;
    int           last_xfer  = 0;
    logic [7:0]   pay [44];
    logic [255:0] exp_mid    = '0;
    logic [95:0]  exp_dat    = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter and "reset was released at the last edge" flag.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            live = rst_n;
        end
    end

    // Monitor: pops expected events and checks held outputs every cycle.
    initial begin
        ev_t e;
        bit  prev_rdy_low;
        prev_rdy_low = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                vectors++;
                if (in_ready !== 1'b0 || midstate !== '0 || data !== '0 ||
                    work_valid !== 1'b0 || frame_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_values: rdy=%b wv=%b fe=%b mid=%h data=%h, required all zero",
                             in_ready, work_valid, frame_err, midstate, data);
                end
                exp_mid      = '0;
                exp_dat      = '0;
                prev_rdy_low = 1'b0;
            end else begin
                if (work_valid || frame_err) begin
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_event: wv=%b fe=%b at cycle %0d, required no event",
                                 work_valid, frame_err, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (work_valid !== e.is_commit || frame_err !== !e.is_commit || cyc != e.cyc) begin
                            miscompares++;
                            $display("FAIL event: wv=%b fe=%b cycle=%0d, required wv=%b fe=%b cycle=%0d",
                                     work_valid, frame_err, cyc, e.is_commit, !e.is_commit, e.cyc);
                        end
                        if (e.is_commit) begin
                            exp_mid = e.mid;
                            exp_dat = e.dat;
                        end
                    end
                end
                vectors++;
                if (midstate !== exp_mid || data !== exp_dat) begin
                    miscompares++;
                    $display("FAIL outputs: mid=%h data=%h, required mid=%h data=%h",
                             midstate, data, exp_mid, exp_dat);
                end
                // in_ready may only drop in the COMMIT cycle, which is
                // always immediately followed by the work_valid cycle.
                if (live) begin
                    vectors++;
                    if (prev_rdy_low != work_valid) begin
                        miscompares++;
                        $display("FAIL in_ready: low_last_cycle=%b wv_now=%b at cycle %0d, required equal",
                                 prev_rdy_low, work_valid, cyc);
                    end
                end
                prev_rdy_low = live && !in_ready;
            end
        end
    end

    // Offer one byte at a negedge; return at the negedge after it transfers.
    task automatic send_byte(input logic [7:0] b);
        int w;
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_wait: in_ready=%b after %0d cycles, required 1", in_ready, w);
        end
        @(posedge clk);
        #1 last_xfer = cyc;
        @(negedge clk);
    endtask

    task automatic gap(input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        if (g > 0) begin
            in_valid = 1'b0;
            repeat (g) @(negedge clk);
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < 44; i++) pay[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic fixed_payload();
        logic [255:0] m;
        logic [95:0]  d;
        m = 256'h228ea4732a3c9ba860c009cda7252b9161a5e75ec8c582a5f106abb3af41f790;
        d = 96'h2194261a9395e64dbed17115;
        for (int i = 0; i < 32; i++) pay[i] = m[255-8*i -: 8];
        for (int i = 0; i < 12; i++) pay[32+i] = d[95-8*i -: 8];
    endtask

    // Full frame from pay[]; queue the outcome the frame rules dictate.
    task automatic send_frame(input bit corrupt, input int maxgap);
        ev_t        e;
        logic [7:0] cs;
        e.mid = '0;
        e.dat = '0;
        cs    = 8'd0;
        for (int i = 0; i < 32; i++) e.mid = (e.mid << 8) | 256'(pay[i]);
        for (int i = 32; i < 44; i++) e.dat = (e.dat << 8) | 96'(pay[i]);
        for (int i = 0; i < 44; i++) cs = cs ^ pay[i];
        gap(maxgap);
        send_byte(8'hA5);
        for (int i = 0; i < 44; i++) begin
            gap(maxgap);
            send_byte(pay[i]);
        end
`ifdef WORK_LOADER_CHECKSUM_EN
        gap(maxgap);
        send_byte(corrupt ? (cs ^ 8'h01) : cs);
        e.is_commit = !corrupt;
        e.cyc       = corrupt ? last_xfer : last_xfer + 1;
`else
        if (corrupt) e.is_commit = 1'b1;
        e.is_commit = 1'b1;
        e.cyc       = last_xfer + 1;
`endif
        sb.push_back(e);
    endtask

    task automatic send_partial(input int n);
        send_byte(8'hA5);
        for (int i = 0; i < n; i++) send_byte(pay[i]);
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        ev_t e;
        int  e1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Known-answer frame.
        fixed_payload();
        send_frame(1'b0, 0);
        idle_cycles(5);
`ifdef WORK_LOADER_CHECKSUM_EN
        // Same frame, bad checksum: error only, outputs held.
        send_frame(1'b1, 0);
        idle_cycles(5);
`endif

        // Leading junk, then a valid frame.
        send_byte(8'h00);
        send_byte(8'h5A);
        send_byte(8'hFF);
        rand_payload();
        send_frame(1'b0, 0);
        idle_cycles(5);

        // Stall 20 bytes in; timeout error, then a fresh frame.
        rand_payload();
        send_partial(20);
        e.is_commit = 1'b0;
        e.mid       = '0;
        e.dat       = '0;
        e.cyc       = last_xfer + C_TO;
        sb.push_back(e);
        idle_cycles(C_TO + 8);
        fixed_payload();
        pay[3] = 8'hA5;
        send_frame(1'b0, 0);
        idle_cycles(5);

        // Reset mid-frame at byte 30, then a clean frame.
        rand_payload();
        send_partial(30);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        rand_payload();
        send_frame(1'b0, 0);
        idle_cycles(5);

        // Back-to-back frames with in_valid held high.
        rand_payload();
        send_frame(1'b0, 0);
        e1 = last_xfer;
        rand_payload();
        send_frame(1'b0, 0);
        in_valid = 1'b0;
        vectors++;
        if (last_xfer - e1 != C_PERIOD) begin
            miscompares++;
            $display("FAIL frame_spacing: %0d cycles, required %0d", last_xfer - e1, C_PERIOD);
        end
        idle_cycles(5);

        // Randomised frames with junk, inter-byte gaps and bad checksums.
        for (int k = 0; k < 8; k++) begin
            int nj;
            nj = int'($urandom_range(0, 3));
            for (int j = 0; j < nj; j++) begin
                logic [7:0] jb;
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h3C;
                send_byte(jb);
            end
            rand_payload();
            send_frame($urandom_range(0, 3) == 0, 3);
            idle_cycles(int'($urandom_range(0, 4)));
        end

        // Drain outstanding expectations.
        in_valid = 1'b0;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL pending_events: %0d outstanding, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/work_loader.md
# work_loader

Byte-serial work receiver feeding the mining core. Accepts a framed byte stream from the host link (UART/JTAG bridge), deserialises a 256-bit SHA-256 midstate and the 96-bit tail of block header chunk 2, and checks the frame. On a good frame it loads the registers that `fpgaminer_top` consumes as `midstate_buf` / `data_buf[95:0]` and pulses `work_valid` so the nonce counter restarts.

## Interface

Parameters:
- `TIMEOUT`, default 32'd1000000: maximum idle cycles between bytes inside a frame before abort.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  received byte.
- `in_valid`  in  1  `in_data` valid this cycle.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `midstate`  out  256  committed midstate.
- `data`  out  96  committed header tail: merkle tail, time, bits.
- `work_valid`  out  1  one-cycle pulse when new work is committed.
- `frame_err`  out  1  one-cycle pulse on a checksum failure or timeout abort.

## Operation

- A byte transfers on a rising edge with `in_valid && in_ready`.
- Frame format: sync byte 8'hA5, then 44 payload bytes, then one checksum byte. The checksum byte is present only with checksum enabled (see Configuration).
- Payload order is MSB first. Bytes 0–31 fill `midstate[255:0]`: byte 0 goes to [255:248]. Bytes 32–43 fill `data[95:0]`: byte 32 goes to [95:88].
- Payload is assembled in a 352-bit shadow shift register. `midstate` and `data` change only on commit and hold otherwise.
- Checksum is the XOR of all 44 payload bytes. A match commits the frame. A mismatch discards it and pulses `frame_err`.
- State machine:
  - IDLE: non-A5 bytes are consumed and dropped. A5 goes to PAYLOAD, and byte count and XOR accumulator are cleared.
  - PAYLOAD: each byte shifts in and count increments 0..43. After byte 43, go to CHECK, or to COMMIT when checksum is disabled.
  - CHECK: the next byte is compared. Match goes to COMMIT. Mismatch pulses `frame_err` and goes to IDLE.
  - COMMIT: `in_ready`=0. Shadow copies to outputs, `work_valid` is pulsed, then go to IDLE.
- Timeout: in PAYLOAD or CHECK, the idle counter increments each cycle with no transfer and clears on each transfer. Reaching `TIMEOUT` pulses `frame_err`, returns to IDLE and drops partial data. The counter is held at 0 in IDLE.
- A5 inside PAYLOAD is payload data, not a resync.
- Reset mid-frame returns to IDLE. Partial data is lost.

## Timing

- Reset values: `in_ready`=0, `midstate`=0, `data`=0, `work_valid`=0, `frame_err`=0, state IDLE.
- `in_ready` is high from the first edge after reset release, in every state except COMMIT.
- Commit latency: final byte accepted at edge N. COMMIT is held during cycle N→N+1. Outputs update at edge N+1. `work_valid` is high for exactly the cycle after edge N+1.
- `frame_err` is high for exactly one cycle, the cycle after the failing byte or the timeout edge.
- The minimum frame period is 47 cycles with checksum enabled (46 without). The loader sustains back-to-back frames at that rate.
- A byte offered during COMMIT is not accepted. The source holds it until `in_ready`.

## Configuration

- `WORK_LOADER_CHECKSUM_EN` defined:
  - The checksum byte is required, with a CHECK state.
  - A mismatch drops the frame and pulses `frame_err`.
- Undefined:
  - The frame is sync plus 44 bytes. The XOR logic and CHECK state are removed.
  - PAYLOAD goes directly to COMMIT.
  - `frame_err` pulses only on timeout.

## Test plan

- Send A5, midstate 228ea4732a3c9ba860c009cda7252b9161a5e75ec8c582a5f106abb3af41f790, data 2194261a9395e64dbed17115, correct XOR. Required: outputs equal these values, one `work_valid` pulse, no `frame_err`.
- Same frame with the checksum byte XOR 8'h01. Required: one `frame_err` pulse, outputs unchanged from the previous commit, no `work_valid`.
- Bytes 00, 5A, FF, then a valid frame. Required: the leading junk is dropped and the frame commits correctly.
- Stall 20 bytes into a frame with `TIMEOUT`=16. Required: `frame_err` 16 cycles after the last byte, then a fresh valid frame commits.
- Assert `rst_n`=0 at byte 30, then send a valid frame after release. Required: all outputs read 0 during reset and the new frame commits cleanly.
- Two back-to-back frames with `in_valid` held high. Required: `in_ready` low only in the COMMIT cycles, and both frames commit with 47-cycle spacing (46 with checksum disabled).
